median_window_3x3: RTL and testbench
====================================

# median_window_3x3

- Raster-scan pixel front end of the median filter.
- Accepts one 8-bit pixel per valid cycle and holds the two previous image lines in internal line buffers.
- Presents a registered 3x3 neighbourhood (nine 8-bit taps) plus a valid strobe.
- Sits directly upstream of the 3-input ascending sorters: each window row or column feeds one sorter.

## Interface
- IMG_WIDTH, default 640: pixels per line; minimum 3.
- IMG_HEIGHT, default 480: lines per frame; minimum 3.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pix_in  in  8  input pixel, unsigned.
- pix_valid  in  1  pix_in is accepted on this edge.
- sof  in  1  start-of-frame tag. Present only with MEDIAN_WIN_SOF_EN.
- w00..w22  out  8 each  window taps wRC:
  - R=0 is the top (oldest) line; R=2 is the current line.
  - C=0 is the leftmost (oldest) column; C=2 is the newest column.
- win_valid  out  1  the window is a complete in-image 3x3 neighbourhood; single-cycle strobe.

## Operation
- Counters:
  - col counts 0..IMG_WIDTH-1; row counts 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels.
  - col wraps to 0 and increments row; row wraps to 0 after the last pixel of a frame.
- Line buffers:
  - lb0 holds the previous line and lb1 the line before it; each is IMG_WIDTH x 8.
  - On an accepted pixel: read lb1[col] and lb0[col], then write lb1[col] <= lb0[col] and lb0[col] <= pix_in.
- New column: top = lb1[col], mid = lb0[col], bot = pix_in.
- Window shift on an accepted pixel:
  - Column 0 <= column 1.
  - Column 1 <= column 2.
  - Column 2 <= new column.
- win_valid rule:
  - Registered 1 if the accepted pixel had row >= 2 and col >= 2; otherwise 0.
  - When valid, the window centre is pixel (row-1, col-1).
- pix_valid = 0: window registers and counters hold, buffers are not written, win_valid = 0 on the next edge.
- Line start: window columns hold stale data from the previous line end. win_valid is low for col 0 and col 1, so the stale data is never flagged.
- Frame start: line buffers hold the previous frame's data. win_valid is low for rows 0 and 1, so the stale data is never flagged.
- Valid windows per frame: exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- Buffer memory has no reset. Its contents before row 2 are don't-care.

## Timing
- Reset values, applied asynchronously on rst = 1: col = 0, row = 0, all w taps = 0x00, win_valid = 0.
- Latency:
  - A pixel accepted at edge N appears as w22 after edge N.
  - The matching win_valid is high for the cycle following edge N.
- Sustained throughput: 1 pixel/cycle with no stall; there is no back-pressure.
- Reset mid-frame: the next accepted pixel is treated as (0,0). No valid window appears until row 2, col 2 of that restart.
- Simultaneous col and row wrap on the last pixel of a frame: both counters return to 0 on the same edge.

## Configuration
- MEDIAN_WIN_SOF_EN defined:
  - sof port exists.
  - sof = 1 together with pix_valid = 1 forces that pixel to position (0,0), regardless of counter state.
  - Counters continue from (0,1) after that pixel.
  - sof with pix_valid = 0 is ignored.
- MEDIAN_WIN_SOF_EN undefined:
  - No sof port.
  - Frame alignment comes purely from counter wrap after reset.

## Test plan
- Async reset: assert rst mid-frame between clock edges -> win_valid = 0 and all taps = 0x00 immediately; the next frame restarts at (0,0).
- Full frame, IMG_WIDTH = 4, IMG_HEIGHT = 4, pixel value = row*16 + col, pix_valid held high:
  - First win_valid follows the 11th pixel, with w00 = 0x00, w01 = 0x01, w02 = 0x02, w10 = 0x10, w11 = 0x11, w12 = 0x12, w20 = 0x20, w21 = 0x21, w22 = 0x22.
  - Exactly 4 strobes per frame.
- Bubbles: same frame with pix_valid randomly low ~50% of cycles -> identical window sequence; win_valid never high in the cycle after an idle edge.
- Back-to-back frames: 2 frames of distinct values, e.g. second frame = value + 0x80 -> second frame yields 4 windows; none contain first-frame values.
- Row boundary, IMG_WIDTH = 5: win_valid is low after col 0 and col 1 of every row, and high after cols 2..4 of rows 2..IMG_HEIGHT-1.
- MEDIAN_WIN_SOF_EN:
  - Send 5 arbitrary pixels, then the frame with sof on its first pixel -> window sequence identical to the full-frame scenario.
  - sof = 1 with pix_valid = 0 -> no effect.

Source files
------------

// File: rtl/median_window_3x3.sv
// Raster-scan 3x3 window generator: two line buffers plus a registered 3x3 tap array.
// Optional start-of-frame alignment input enabled by MEDIAN_WIN_SOF_EN.
module median_window_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
`ifdef MEDIAN_WIN_SOF_EN
  input  logic              sof,
`endif
  output logic [DATA_W-1:0] w00,
  output logic [DATA_W-1:0] w01,
  output logic [DATA_W-1:0] w02,
  output logic [DATA_W-1:0] w10,
  output logic [DATA_W-1:0] w11,
  output logic [DATA_W-1:0] w12,
  output logic [DATA_W-1:0] w20,
  output logic [DATA_W-1:0] w21,
  output logic [DATA_W-1:0] w22,
  output logic              win_valid
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [COL_W-1:0]  col, cur_col;
  logic [ROW_W-1:0]  row, cur_row;
  logic              sof_hit;
  logic              last_col, last_row;
  logic [DATA_W-1:0] top, mid;

  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];

  logic [DATA_W-1:0] win_p0 [3][3];
  logic              vld_p0;

  // A start-of-frame pixel overrides the counters and is placed at (0,0).
  always_comb begin
`ifdef MEDIAN_WIN_SOF_EN
    sof_hit = pix_valid & sof;
`else
    sof_hit = 1'b0;
`endif
    cur_col  = sof_hit ? '0 : col;
    cur_row  = sof_hit ? '0 : row;
    last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
    last_row = (cur_row == ROW_W'(IMG_HEIGHT - 1));
    top      = lb1[cur_col];
    mid      = lb0[cur_col];
  end

  // Line buffers carry no reset; their content is only trusted from row 2 on.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1[cur_col] <= mid;
      lb0[cur_col] <= pix_in;
    end
  end

  // Stage p0: counters advance, window shifts left, new column enters on the right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      vld_p0 <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_p0[r][c] <= '0;
    end else if (pix_valid) begin
      col <= last_col ? '0 : cur_col + COL_W'(1);
      if (last_col)
        row <= last_row ? '0 : cur_row + ROW_W'(1);
      else
        row <= cur_row;
      for (int r = 0; r < 3; r++) begin
        win_p0[r][0] <= win_p0[r][1];
        win_p0[r][1] <= win_p0[r][2];
      end
      win_p0[0][2] <= top;
      win_p0[1][2] <= mid;
      win_p0[2][2] <= pix_in;
      vld_p0 <= (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    end else begin
      vld_p0 <= 1'b0;
    end
  end

  assign w00       = win_p0[0][0];
  assign w01       = win_p0[0][1];
  assign w02       = win_p0[0][2];
  assign w10       = win_p0[1][0];
  assign w11       = win_p0[1][1];
  assign w12       = win_p0[1][2];
  assign w20       = win_p0[2][0];
  assign w21       = win_p0[2][1];
  assign w22       = win_p0[2][2];
  assign win_valid = vld_p0;

endmodule

// File: tb/tb_median_window_3x3.sv
// Directed bench for median_window_3x3: a 4x4 instance and a 5-wide instance,
// with optional start-of-frame checks when MEDIAN_WIN_SOF_EN is defined.
module tb_median_window_3x3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in, pix5_in;
  logic       pix_valid, pix5_valid;
`ifdef MEDIAN_WIN_SOF_EN
  logic       sof;
`endif

  logic [7:0] wa [9];
  logic [7:0] wb [9];
  logic       vld_a, vld_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  median_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
`ifdef MEDIAN_WIN_SOF_EN
    .sof(sof),
`endif
    .w00(wa[0]), .w01(wa[1]), .w02(wa[2]),
    .w10(wa[3]), .w11(wa[4]), .w12(wa[5]),
    .w20(wa[6]), .w21(wa[7]), .w22(wa[8]),
    .win_valid(vld_a)
  );

  median_window_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) dut5 (
    .clk(clk), .rst(rst), .pix_in(pix5_in), .pix_valid(pix5_valid),
`ifdef MEDIAN_WIN_SOF_EN
    .sof(1'b0),
`endif
    .w00(wb[0]), .w01(wb[1]), .w02(wb[2]),
    .w10(wb[3]), .w11(wb[4]), .w12(wb[5]),
    .w20(wb[6]), .w21(wb[7]), .w22(wb[8]),
    .win_valid(vld_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_sof(input bit s);
`ifdef MEDIAN_WIN_SOF_EN
    sof = s;
`else
    if (s) $display("note: sof requested without sof port");
`endif
  endtask

  task automatic drive(input int w, input bit v, input logic [7:0] p, input bit s);
    if (w == 4) begin pix_valid = v; pix_in = p; end
    else        begin pix5_valid = v; pix5_in = p; end
    set_sof(s);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix5_valid = 1'b0;
    set_sof(1'b0);
  endtask

  // One frame of base + row*16 + col; window for pixel (r,c) holds rows r-2..r, cols c-2..c.
  task automatic run_frame(input int w, input int base, input bit bub,
                           input bit sof_first, input bit sof_idle);
    int   nwin;
    bit   ov, ev;
    logic [7:0] t [9];
    nwin = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < w; c++) begin
        if (bub) begin
          for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
            drive(w, 1'b0, 8'($urandom), sof_idle);
            ov = (w == 4) ? vld_a : vld_b;
            check($sformatf("idle_vld w%0d r%0d c%0d", w, r, c), int'(ov), 0);
          end
        end
        drive(w, 1'b1, 8'(base + r * 16 + c), sof_first && r == 0 && c == 0);
        ov = (w == 4) ? vld_a : vld_b;
        for (int i = 0; i < 9; i++) t[i] = (w == 4) ? wa[i] : wb[i];
        ev = (r >= 2) && (c >= 2);
        check($sformatf("vld w%0d r%0d c%0d", w, r, c), int'(ov), int'(ev));
        check($sformatf("w22 w%0d r%0d c%0d", w, r, c), int'(t[8]), (base + r * 16 + c) & 8'hff);
        if (ov) nwin++;
        if (ev) begin
          for (int R = 0; R < 3; R++)
            for (int C = 0; C < 3; C++)
              check($sformatf("tap%0d%0d w%0d r%0d c%0d", R, C, w, r, c),
                    int'(t[R * 3 + C]), (base + (r - 2 + R) * 16 + (c - 2 + C)) & 8'hff);
        end
      end
    end
    check($sformatf("strobes w%0d base%0h", w, base), nwin, 2 * (w - 2));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"}, int'(vld_a), 0);
    for (int i = 0; i < 9; i++) check($sformatf("%s_tap%0d", tag, i), int'(wa[i]), 0);
  endtask

  initial begin
    rst = 1'b1;
    pix_in = '0; pix_valid = 1'b0;
    pix5_in = '0; pix5_valid = 1'b0;
    set_sof(1'b0);
    #3;
    check_zero("reset");
    check("reset_vld5", int'(vld_b), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(4, 8'h00, 1'b0, 1'b0, 1'b0);
    run_frame(4, 8'h80, 1'b0, 1'b0, 1'b0);
    run_frame(4, 8'h00, 1'b1, 1'b0, 1'b0);

    // Stop mid-frame right after the first valid window, then reset between edges.
    for (int p = 0; p < 11; p++) drive(4, 1'b1, 8'(8'h40 + (p / 4) * 16 + (p % 4)), 1'b0);
    check("pre_reset_vld", int'(vld_a), 1);
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(4, 8'h40, 1'b0, 1'b0, 1'b0);

    run_frame(5, 8'h00, 1'b0, 1'b0, 1'b0);
    run_frame(5, 8'h80, 1'b1, 1'b0, 1'b0);

`ifdef MEDIAN_WIN_SOF_EN
    for (int p = 0; p < 5; p++) begin
      drive(4, 1'b1, 8'($urandom), 1'b0);
      check($sformatf("junk_vld %0d", p), int'(vld_a), 0);
    end
    run_frame(4, 8'h00, 1'b0, 1'b1, 1'b0);
    run_frame(4, 8'h80, 1'b1, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
